// File: rtl/psg_pkg.sv
// Shared types and constants for the PSG voice VCA/mixer.
package psg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } vca_state_t;

    localparam int VCA_SHIFT = 12;
    localparam int ENV_W     = 8;
    localparam int VOL_W     = 4;

endpackage

// File: rtl/psg_env_exp_rom.sv
// Exponential envelope curve ROM: 0 -> 0, else round(255*2^((env-255)/32)).
// Only compiled when PSG_VCA_EXP_EN is defined; the table is folded at elaboration.
`ifdef PSG_VCA_EXP_EN
module psg_env_exp_rom (
    input  logic [7:0] addr_i,
    output logic [7:0] data_o
);

    function automatic longint isqrt(input longint v_in);
        longint v, res, b;
        v   = v_in;
        res = 0;
        b   = longint'(1) <<< 60;
        while (b > v) b = b >>> 2;
        while (b != 0) begin
            if (v >= res + b) begin
                v   = v - (res + b);
                res = (res >>> 1) + b;
            end else begin
                res = res >>> 1;
            end
            b = b >>> 2;
        end
        return res;
    endfunction

    // Q30 fixed point: 2^(-1/32) via five square roots of 0.5, then r powers and q halvings.
    function automatic logic [7:0] exp_val(input int a);
        longint c, f, y;
        int     d, q, r;
        if (a == 0) return 8'd0;
        d = 255 - a;
        q = d / 32;
        r = d % 32;
        c = longint'(1) <<< 29;
        for (int i = 0; i < 5; i++) c = isqrt(c <<< 30);
        f = longint'(1) <<< 30;
        for (int i = 0; i < r; i++) f = (f * c + (longint'(1) <<< 29)) >>> 30;
        y = (255 * f + (longint'(1) <<< (29 + q))) >>> (30 + q);
        return y[7:0];
    endfunction

    logic [7:0] rom [256];

    for (genvar a = 0; a < 256; a++) begin : g_rom
        localparam logic [7:0] VAL = exp_val(a);
        assign rom[a] = VAL;
    end

    assign data_o = rom[addr_i];

endmodule
`endif

// File: rtl/psg_voice_vca_mixer.sv
// Time-multiplexed voice VCA and mixer: sum of wave*env*vol per frame, saturated to OW bits.
// Define PSG_VCA_EXP_EN for the exponential envelope curve (ROM); default is linear.
module psg_voice_vca_mixer
    import psg_pkg::*;
#(
    parameter int NVOICE = 4,
    parameter int WW     = 12,
    parameter int OW     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     srst,
    input  logic                     tick,
    input  logic [NVOICE*WW-1:0]     wave,
    input  logic [NVOICE*ENV_W-1:0]  env,
    input  logic [NVOICE*VOL_W-1:0]  vol,
    input  logic [NVOICE-1:0]        mute,
    output logic signed [OW-1:0]     o,
    output logic                     o_valid,
    output logic                     busy,
    output logic                     o_overrun
);

    // state | meaning
    // IDLE  | waiting for tick; inputs snapshotted on accept
    // RUN   | issue one voice per cycle into S1
    // DRAIN | 3 cycles for S1..S3 and the accumulator to settle
    // DONE  | register saturated result, pulse o_valid

    localparam int VCW = $clog2(NVOICE);
    localparam int AW  = WW + VCW + 1;
    localparam int P1W = WW + ENV_W + 1;
    localparam int P2W = P1W + VOL_W + 1;
    localparam int TW  = P2W - VCA_SHIFT;
    localparam int SW  = AW + OW - WW;

    vca_state_t              state_q;
    logic [VCW-1:0]          vcnt_q;
    logic [1:0]              dcnt_q;

    logic signed [WW-1:0]    wave_q [NVOICE];
    logic [ENV_W-1:0]        env_q  [NVOICE];
    logic [VOL_W-1:0]        vol_q  [NVOICE];
    logic [NVOICE-1:0]       mute_q;

    logic                    s1_v_q, s2_v_q, s3_v_q;
    logic signed [WW-1:0]    s1_wave_q;
    logic [ENV_W-1:0]        s1_e_q;
    logic [VOL_W-1:0]        s1_vol_q, s2_vol_q;
    logic signed [P1W-1:0]   s2_p1_q;
    logic signed [TW-1:0]    s3_term_q;
    logic signed [AW-1:0]    acc_q;

    logic signed [OW-1:0]    o_q;
    logic                    o_valid_q, busy_q, overrun_q;

    logic [ENV_W-1:0]        env_cur, env_map, e_d;
    logic signed [P1W-1:0]   p1_d;
    logic signed [P2W-1:0]   p2_d;
    logic signed [TW-1:0]    term_d;
    logic signed [AW-1:0]    term_ext;
    logic signed [SW-1:0]    sh_d;
    logic signed [OW-1:0]    o_d;

`ifdef PSG_VCA_EXP_EN
    psg_env_exp_rom u_exp_rom (
        .addr_i (env_cur),
        .data_o (env_map)
    );
`else
    assign env_map = env_cur;
`endif

    always_comb begin
        env_cur  = env_q[vcnt_q];
        e_d      = mute_q[vcnt_q] ? '0 : env_map;
        p1_d     = P1W'(s1_wave_q) * P1W'($signed({1'b0, s1_e_q}));
        p2_d     = P2W'(s2_p1_q) * P2W'($signed({1'b0, s2_vol_q}));
        term_d   = $signed(p2_d[P2W-1:VCA_SHIFT]);
        term_ext = AW'(s3_term_q);
        sh_d     = SW'(acc_q) <<< (OW - WW);
        // In range only when all bits above the output sign bit match it.
        if ((&sh_d[SW-1:OW-1]) || ~(|sh_d[SW-1:OW-1])) begin
            o_d = sh_d[OW-1:0];
        end else if (sh_d[SW-1]) begin
            o_d = {1'b1, {(OW-1){1'b0}}};
        end else begin
            o_d = {1'b0, {(OW-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || srst) begin
            state_q   <= IDLE;
            vcnt_q    <= '0;
            dcnt_q    <= '0;
            for (int k = 0; k < NVOICE; k++) begin
                wave_q[k] <= '0;
                env_q[k]  <= '0;
                vol_q[k]  <= '0;
            end
            mute_q    <= '0;
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            s3_v_q    <= 1'b0;
            s1_wave_q <= '0;
            s1_e_q    <= '0;
            s1_vol_q  <= '0;
            s2_vol_q  <= '0;
            s2_p1_q   <= '0;
            s3_term_q <= '0;
            acc_q     <= '0;
            o_q       <= '0;
            o_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            o_valid_q <= 1'b0;
            overrun_q <= tick && busy_q;
            s1_v_q    <= 1'b0;
            s2_v_q    <= s1_v_q;
            s2_p1_q   <= p1_d;
            s2_vol_q  <= s1_vol_q;
            s3_v_q    <= s2_v_q;
            s3_term_q <= term_d;
            if (s3_v_q) acc_q <= acc_q + term_ext;

            case (state_q)
                IDLE: begin
                    if (o_valid_q) busy_q <= 1'b0;
                    if (tick && !busy_q) begin
                        for (int k = 0; k < NVOICE; k++) begin
                            wave_q[k] <= $signed(wave[k*WW +: WW]);
                            env_q[k]  <= env[k*ENV_W +: ENV_W];
                            vol_q[k]  <= vol[k*VOL_W +: VOL_W];
                        end
                        mute_q  <= mute;
                        acc_q   <= '0;
                        vcnt_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    s1_v_q    <= 1'b1;
                    s1_wave_q <= wave_q[vcnt_q];
                    s1_e_q    <= e_d;
                    s1_vol_q  <= vol_q[vcnt_q];
                    if (vcnt_q == VCW'(NVOICE - 1)) begin
                        dcnt_q  <= '0;
                        state_q <= DRAIN;
                    end else begin
                        vcnt_q <= vcnt_q + VCW'(1);
                    end
                end
                DRAIN: begin
                    if (dcnt_q == 2'd2) state_q <= DONE;
                    else                dcnt_q  <= dcnt_q + 2'd1;
                end
                DONE: begin
                    o_q       <= o_d;
                    o_valid_q <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o         = o_q;
    assign o_valid   = o_valid_q;
    assign busy      = busy_q;
    assign o_overrun = overrun_q;

endmodule
